dm_access_unit: RTL and testbench

Memory-stage data access unit for the pipelined RISC-V core. It consumes the decoder's MemWrite/load decode and `dm_ctrl` size code and turns each load or store into one word-aligned bus transaction with byte enables. A req/ack handshake lets the memory take a variable number of cycles, and the block stalls the pipeline until the access completes. It sign- or zero-extends load data before writeback.

---
 rtl/dm_access_unit.sv | 160 ++++++++++++++++
 tb/tb_dm_access_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - memory-stage load/store unit: one word-aligned bus transaction per access
//
// Optional build macro: DM_MISALIGN_TRAP_EN (reject misaligned word/half accesses with misalign_err)
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   mem_read, mem_write       MEM-stage load / store decode (both set => store)
//   dm_ctrl[2:0]              size code: 000 w, 001 h, 010 hu, 011 b, 100 bu, others = word
//   addr[31:0], wdata[31:0]   byte address and store data
//   stall                     pipeline freeze while an access is outstanding
//   rdata[31:0], rdata_valid  extended load result, valid for one cycle in DONE
//   misalign_err              one-cycle pulse on a rejected access (0 unless macro defined)
//   bus_req/we/addr/be/wdata  bus request fields, held stable while bus_req is high
//   bus_ack, bus_rdata        bus completion and read word (same cycle)
`timescale 1ns/1ps
module dm_access_unit #(
    parameter int BUS_AW = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        dm_ctrl,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              misalign_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              we_q;
    logic [BUS_AW-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [2:0]        ctrl_q;
    logic [1:0]        lane_q;

    logic        access, is_half, is_byte, misaligned, accept;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] ext_d;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign access  = mem_read | mem_write;
    assign is_half = (dm_ctrl == 3'b001) || (dm_ctrl == 3'b010);
    assign is_byte = (dm_ctrl == 3'b011) || (dm_ctrl == 3'b100);

`ifdef DM_MISALIGN_TRAP_EN
    // Codes 101-111 behave as word, so anything not half/byte needs addr[1:0]==0.
    assign misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
`else
    // Misaligned addresses are truncated by the lane logic below instead.
    assign misaligned = 1'b0;
`endif

    assign accept       = (state_q == S_IDLE) && access && !misaligned;
    // Gated by rstn so both drop the moment reset asserts, even with inputs still present.
    assign stall        = rstn & (accept | (state_q == S_WAIT));
    assign misalign_err = rstn & (state_q == S_IDLE) & access & misaligned;

    assign bus_req     = (state_q == S_WAIT);
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state_q == S_DONE) && !we_q;

    // Store lane placement; loads always read the full word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        if (mem_write) begin
            if (is_half) begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata[15:0]}};
            end else if (is_byte) begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
        end
    end

    // Load lane selection uses the captured address, extension uses the captured size code.
    always_comb begin
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lane_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        case (ctrl_q)
            3'b001:  ext_d = {{16{half_sel[15]}}, half_sel};
            3'b010:  ext_d = {16'h0000, half_sel};
            3'b011:  ext_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_d = {24'h000000, byte_sel};
            default: ext_d = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_WAIT;
            S_WAIT:  if (bus_ack) state_d = S_DONE;
            // The pipeline advances on this edge, so the instruction is never re-issued.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ctrl_q  <= 3'b000;
            lane_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= mem_write;
                addr_q  <= {addr[BUS_AW-1:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
                ctrl_q  <= dm_ctrl;
                lane_q  <= addr[1:0];
            end
            if ((state_q == S_WAIT) && bus_ack && !we_q) begin
                rdata_q <= ext_d;
            end
`ifdef DM_MISALIGN_TRAP_EN
            // A rejected load reports a zero result.
            if (misalign_err && !mem_write) begin
                rdata_q <= 32'h0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - scoreboard testbench for dm_access_unit
`timescale 1ns/1ps
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  dm_ctrl = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int passed = 0;
    int total  = 0;

    logic [68:0] bus_q[$];
    logic [31:0] rd_q[$];

    always #5 clk = ~clk;

    dm_access_unit #(.BUS_AW(32)) dut (
        .clk(clk), .rstn(rstn), .mem_read(mem_read), .mem_write(mem_write),
        .dm_ctrl(dm_ctrl), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .misalign_err(misalign_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops expected bus fields on each bus_req rise, checks they stay put while
    // bus_req is high, and pops the expected load result whenever rdata_valid is seen.
    initial begin
        logic        prev;
        logic [68:0] cur;
        prev = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    cur = bus_q.pop_front();
                    chk("bus_we", {31'd0, bus_we}, {31'd0, cur[68]});
                    chk("bus_addr", bus_addr, cur[67:36]);
                    chk("bus_be", {28'd0, bus_be}, {28'd0, cur[35:32]});
                    if (cur[68]) chk("bus_wdata", bus_wdata, cur[31:0]);
                end
            end else if (bus_req && prev) begin
                chk("bus_hold_addr", bus_addr, cur[67:36]);
                chk("bus_hold_be", {28'd0, bus_be}, {28'd0, cur[35:32]});
            end
            prev = bus_req;
            if (rdata_valid) begin
                if (rd_q.size() == 0) chk("rdata_unexpected", 32'd1, 32'd0);
                else chk("rdata", rdata, rd_q.pop_front());
            end
        end
    end

    // One access: ack is driven in the delay-th cycle that bus_req is high.
    task automatic do_acc(input logic rd, input logic wr, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                          input int delay, input logic spur,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic [31:0] e_rd);
        int   stalls, reqs, valids, cyc;
        logic done;
        bus_q.push_back({wr, e_addr, e_be, e_wd});
        if (!wr) rd_q.push_back(e_rd);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; dm_ctrl = ctrl; addr = a; wdata = wd;
        stalls = 0; reqs = 0; valids = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (stall) stalls++;
            if (rdata_valid) valids++;
            chk("misalign_idle", {31'd0, misalign_err}, 32'd0);
            if (bus_req) begin
                reqs++;
                if (reqs == delay) begin
                    bus_ack = 1'b1;
                    bus_rdata = rword;
                end
            end else if (reqs > 0) begin
                done = 1'b1;
                if (spur) begin
                    bus_ack = 1'b1;
                    bus_rdata = 32'hFFFF_FFFF;
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            cyc++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        chk("done_in_budget", {31'd0, done}, 32'd1);
        chk("stall_cycles", stalls, delay + 1);
        chk("req_cycles", reqs, delay);
        chk("valid_cycles", valids, wr ? 32'd0 : 32'd1);
        @(negedge clk);
        chk("idle_req", {31'd0, bus_req}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_valid", {31'd0, rdata_valid}, 32'd0);
        if (!wr) chk("rdata_hold", rdata, e_rd);
    endtask

    initial begin
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        @(posedge clk); #1 rstn = 1'b1;

        //     rd    wr    ctrl    addr          wdata         rword         dly spur  e_addr        e_be     e_wdata       e_rdata
        do_acc(1'b0, 1'b1, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        do_acc(1'b0, 1'b1, 3'b011, 32'h0000_0103, 32'h0000_00A5, 32'h0,        2, 1'b0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        do_acc(1'b0, 1'b1, 3'b001, 32'h0000_0106, 32'h1234_ABCD, 32'h0,        1, 1'b0, 32'h0000_0104, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_acc(1'b1, 1'b0, 3'b011, 32'h0000_0201, 32'h0,         32'h80F0_7F81, 1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_007F);
        do_acc(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h80F0_7F81, 1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_0080);
        do_acc(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'h80F0_7F81, 2, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFF_80F0);
        do_acc(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'h80F0_7F81, 1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_7F81);
        do_acc(1'b1, 1'b0, 3'b011, 32'h0000_0203, 32'h0,         32'h80F0_7F81, 1, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,        32'hFFFF_FF80);
        do_acc(1'b1, 1'b0, 3'b000, 32'h0000_0300, 32'h0,         32'h1357_9BDF, 5, 1'b1, 32'h0000_0300, 4'b1111, 32'h0,        32'h1357_9BDF);
        do_acc(1'b1, 1'b1, 3'b100, 32'h0000_0401, 32'h0000_005A, 32'h0,        1, 1'b0, 32'h0000_0400, 4'b0010, 32'h5A5A_5A5A, 32'h0);
        do_acc(1'b1, 1'b0, 3'b101, 32'h0000_0500, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 32'h0000_0500, 4'b1111, 32'h0,        32'hCAFE_F00D);

        // Reset while waiting: bus_req and stall must drop without a clock edge.
        bus_q.push_back({1'b0, 32'h0000_0600, 4'b1111, 32'h0});
        @(posedge clk); #1;
        mem_read = 1'b1; dm_ctrl = 3'b000; addr = 32'h0000_0600;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, bus_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        mem_read = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        do_acc(1'b0, 1'b1, 3'b000, 32'h0000_0700, 32'h0BAD_F00D, 32'h0, 1, 1'b0, 32'h0000_0700, 4'b1111, 32'h0BAD_F00D, 32'h0);

`ifdef DM_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        mem_read = 1'b1; dm_ctrl = 3'b000; addr = 32'h0000_0102;
        @(negedge clk);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_req", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1 mem_read = 1'b0;
        @(negedge clk);
        chk("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
        chk("mis_req_after", {31'd0, bus_req}, 32'd0);
        chk("mis_valid", {31'd0, rdata_valid}, 32'd0);
        chk("mis_rdata", rdata, 32'd0);
`else
        do_acc(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h2468_ACE0, 1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'h2468_ACE0);
`endif

        repeat (2) @(negedge clk);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
